// File: rtl/arith_control_unit_if.sv
// Bundle of handshake, status and control lines between the arithmetic
// sequencer and its requester/datapath. The master side issues requests and
// supplies the datapath flags. The slave side is the sequencer, which drives
// the control lines.
interface arith_control_unit_if;
  logic       start;
  logic [1:0] op_in;
  logic       cnt_ok;
  logic       q0;
  logic       qminus1;
  logic       a7;
  logic [1:0] op;
  logic       c0;
  logic       c1;
  logic       c2;
  logic       c3;
  logic       c4;
  logic       c5;
  logic       c6;
  logic       c7;
  logic       c8;
  logic       c9;
  logic       c10;
  logic       internal_rst;
  logic       busy;
  logic       done;

  modport master (
    output start, op_in, cnt_ok, q0, qminus1, a7,
    input  op, c0, c1, c2, c3, c4, c5, c6, c7, c8, c9, c10,
           internal_rst, busy, done
  );

  modport slave (
    input  start, op_in, cnt_ok, q0, qminus1, a7,
    output op, c0, c1, c2, c3, c4, c5, c6, c7, c8, c9, c10,
           internal_rst, busy, done
  );
endinterface

// File: rtl/arith_control_unit.sv
// Sequencer for the 8-bit arithmetic datapath. It clears the datapath, loads
// X then Y from inbus, and runs one of three algorithms: single-step add/sub,
// radix-2 Booth multiply (8 iterations) or restoring divide (8 iterations).
// It then presents the result and pulses done.
// Optional feature: define ARITH_CTRL_STATE_DEBUG_EN to expose the raw state
// encoding on the state_dbg[3:0] port.
module arith_control_unit (
  input  logic                 clk,
  input  logic                 rst,
  arith_control_unit_if.slave  bus
`ifdef ARITH_CTRL_STATE_DEBUG_EN
  ,
  output logic [3:0]           state_dbg
`endif
);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    INIT      = 4'd1,
    LOAD_X    = 4'd2,
    LOAD_Y    = 4'd3,
    ADDSUB    = 4'd4,
    MUL_TEST  = 4'd5,
    MUL_SHIFT = 4'd6,
    DIV_SHIFT = 4'd7,
    DIV_SUB   = 4'd8,
    DIV_TEST  = 4'd9,
    OUT       = 4'd10
  } state_t;

  state_t      state;
  logic [1:0]  op_reg;
  logic [10:0] ctrl;
  logic        internal_rst_c;
  logic        busy_c;
  logic        done_c;

  // State sequencing and operation latch. The iteration loops end on the
  // datapath's cnt_ok flag, which is read before this cycle's c5 increment.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      op_reg <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            op_reg <= bus.op_in;
            state  <= INIT;
          end
        end
        INIT:      state <= LOAD_X;
        LOAD_X:    state <= LOAD_Y;
        LOAD_Y: begin
          if (!op_reg[1])     state <= ADDSUB;
          else if (!op_reg[0]) state <= MUL_TEST;
          else                state <= DIV_SHIFT;
        end
        ADDSUB:    state <= OUT;
        MUL_TEST:  state <= MUL_SHIFT;
        MUL_SHIFT: state <= bus.cnt_ok ? OUT : MUL_TEST;
        DIV_SHIFT: state <= DIV_SUB;
        DIV_SUB:   state <= DIV_TEST;
        DIV_TEST:  state <= bus.cnt_ok ? OUT : DIV_SHIFT;
        OUT:       state <= IDLE;
        default:   state <= IDLE;
      endcase
    end
  end

  // Control decode from the state register and the datapath flags only, so
  // start and op_in never reach the control lines combinationally.
  always_comb begin
    ctrl           = '0;
    internal_rst_c = 1'b0;
    busy_c         = (state != IDLE);
    done_c         = 1'b0;
    case (state)
      INIT:   internal_rst_c = 1'b1;
      LOAD_X: ctrl[1] = 1'b1;
      LOAD_Y: ctrl[0] = 1'b1;
      ADDSUB: begin
        ctrl[2] = 1'b1;
        ctrl[3] = op_reg[0];
      end
      MUL_TEST: begin
        case ({bus.q0, bus.qminus1})
          2'b01: ctrl[2] = 1'b1;
          2'b10: begin
            ctrl[2] = 1'b1;
            ctrl[3] = 1'b1;
          end
          default: ctrl[2] = 1'b0;
        endcase
      end
      MUL_SHIFT: begin
        ctrl[4] = 1'b1;
        ctrl[5] = 1'b1;
        ctrl[6] = bus.a7;
      end
      DIV_SHIFT: ctrl[4] = 1'b1;
      DIV_SUB: begin
        ctrl[2] = 1'b1;
        ctrl[3] = 1'b1;
      end
      DIV_TEST: begin
        ctrl[5]  = 1'b1;
        ctrl[10] = 1'b1;
        if (bus.a7) ctrl[2] = 1'b1;
        else        ctrl[6] = 1'b1;
      end
      OUT: begin
        ctrl[7] = 1'b1;
        ctrl[8] = 1'b1;
        done_c  = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

  assign bus.op           = op_reg;
  assign bus.c0           = ctrl[0];
  assign bus.c1           = ctrl[1];
  assign bus.c2           = ctrl[2];
  assign bus.c3           = ctrl[3];
  assign bus.c4           = ctrl[4];
  assign bus.c5           = ctrl[5];
  assign bus.c6           = ctrl[6];
  assign bus.c7           = ctrl[7];
  assign bus.c8           = ctrl[8];
  assign bus.c9           = ctrl[9];
  assign bus.c10          = ctrl[10];
  assign bus.internal_rst = internal_rst_c;
  assign bus.busy         = busy_c;
  assign bus.done         = done_c;

`ifdef ARITH_CTRL_STATE_DEBUG_EN
  assign state_dbg = state;
`endif

endmodule

// File: tb/tb_arith_control_unit.sv
// Self-checking bench for arith_control_unit. A behavioural datapath model
// reacts to the control lines. Results are compared with plain arithmetic,
// and done timing is compared with the fixed per-operation latency.
module tb_arith_control_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  inbus;
  logic        flag_force;
  logic [3:0]  flag_val;
  logic [7:0]  dp_a, dp_q, dp_m;
  logic        dp_qm1;
  logic [2:0]  dp_cnt;
  logic [15:0] outbus;
  logic [15:0] outs_vec;
  int          assert_count = 0;
  int          fail_count = 0;

  always #5 clk = ~clk;

  arith_control_unit_if bus();

`ifdef ARITH_CTRL_STATE_DEBUG_EN
  logic [3:0] state_dbg;
`endif

  arith_control_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef ARITH_CTRL_STATE_DEBUG_EN
    ,
    .state_dbg (state_dbg)
`endif
  );

  // Status flags come from the datapath model unless deliberately scrambled.
  assign bus.cnt_ok  = flag_force ? flag_val[0] : (dp_cnt == 3'd7);
  assign bus.q0      = flag_force ? flag_val[1] : dp_q[0];
  assign bus.qminus1 = flag_force ? flag_val[2] : dp_qm1;
  assign bus.a7      = flag_force ? flag_val[3] : dp_a[7];

  assign outs_vec = {bus.op, bus.c10, bus.c9, bus.c8, bus.c7, bus.c6, bus.c5,
                     bus.c4, bus.c3, bus.c2, bus.c1, bus.c0,
                     bus.internal_rst, bus.busy, bus.done};

  // Behavioural datapath: A/Q/M registers, Booth bit, 3-bit iteration counter.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      dp_a <= 8'h00; dp_q <= 8'h00; dp_m <= 8'h00; dp_qm1 <= 1'b0;
      dp_cnt <= 3'd0; outbus <= 16'h0000;
    end else if (bus.internal_rst) begin
      dp_a <= 8'h00; dp_q <= 8'h00; dp_m <= 8'h00; dp_qm1 <= 1'b0;
      dp_cnt <= 3'd0;
    end else begin
      if (bus.c1) dp_q <= inbus;
      if (bus.c0) dp_m <= inbus;
      if (bus.c2) dp_a <= (bus.op[1] ? dp_a : dp_q) + (bus.c3 ? (~dp_m + 8'd1) : dp_m);
      if (bus.c4) begin
        if (bus.op == 2'b10) {dp_a, dp_q, dp_qm1} <= {bus.c6, dp_a, dp_q};
        else                 {dp_a, dp_q} <= {dp_a[6:0], dp_q, bus.c6};
      end
      if (bus.c10) dp_q[0] <= bus.c6;
      if (bus.c5) dp_cnt <= dp_cnt + 3'd1;
      if (bus.c7 && bus.c8) outbus <= {dp_a, dp_q};
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assert_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // One operation from start to the idle cycle after done. hold_cycles is
  // how many cycles start stays high, starting at the request cycle.
  task automatic applyStimulus(input logic [1:0] opc, input logic [7:0] x,
                               input logic [7:0] y, input int hold_cycles);
    int          exp_done, exp_iter, done_at, done_count;
    int          c4_count, c5_count, busy_bad, sec_done, prod;
    logic [15:0] exp_out, res_mask;
    prod = $signed(x) * $signed(y);
    case (opc)
      2'b00:   begin exp_done = 5;  exp_iter = 0; exp_out = {x + y, 8'h00}; res_mask = 16'hFF00; end
      2'b01:   begin exp_done = 5;  exp_iter = 0; exp_out = {x - y, 8'h00}; res_mask = 16'hFF00; end
      2'b10:   begin exp_done = 20; exp_iter = 8; exp_out = 16'(prod);      res_mask = 16'hFFFF; end
      default: begin exp_done = 28; exp_iter = 8; exp_out = {x % y, x / y}; res_mask = 16'hFFFF; end
    endcase
    done_at = -1; done_count = 0; c4_count = 0; c5_count = 0; busy_bad = 0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.op_in = opc;
    flag_force = !opc[1];
    @(posedge clk);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k >= hold_cycles) bus.start = 1'b0;
      bus.op_in = 2'($urandom);
      inbus = (k == 2) ? x : (k == 3) ? y : 8'($urandom);
      flag_val = 4'($urandom);
      if (done_at < 0) begin
        if (bus.busy !== 1'b1) busy_bad++;
        if (bus.c4) c4_count++;
        if (bus.c5) c5_count++;
        if (k == 4 && !opc[1]) begin
          checkOutput("addsub_c2", 32'(bus.c2), 1);
          checkOutput("addsub_c3", 32'(bus.c3), 32'(opc[0]));
        end
      end
      if (bus.done) begin
        done_count++;
        if (done_at < 0) begin
          done_at = k;
          checkOutput("op_reg", 32'(bus.op), 32'(opc));
        end
      end
      if (done_at >= 0 && k == done_at + 1) begin
        checkOutput("done_pulse_count", done_count, 1);
        checkOutput("busy_after_done", 32'(bus.busy), 0);
        checkOutput("result", 32'(outbus & res_mask), 32'(exp_out & res_mask));
        break;
      end
    end
    checkOutput("done_cycle", done_at, exp_done);
    checkOutput("busy_window", busy_bad, 0);
    checkOutput("iter_shifts", c4_count, exp_iter);
    checkOutput("iter_counts", c5_count, exp_iter);
    if (hold_cycles > exp_done + 1) begin
      @(negedge clk);
      bus.start = 1'b0;
      checkOutput("held_restart_busy", 32'(bus.busy), 1);
      sec_done = 0;
      for (int k = 0; k < 40 && sec_done == 0; k++) begin
        @(negedge clk);
        inbus = 8'($urandom);
        if (bus.done) sec_done = 1;
      end
      checkOutput("held_second_done", sec_done, 1);
      @(negedge clk);
      checkOutput("held_idle", 32'(bus.busy), 0);
    end
    flag_force = 1'b0;
  endtask

  // Asynchronous reset pulse during the fourth MUL_SHIFT of a multiply.
  task automatic resetMidMul();
    @(negedge clk);
    bus.start = 1'b1;
    bus.op_in = 2'b10;
    @(posedge clk);
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      inbus = 8'($urandom);
    end
    checkOutput("pre_reset_busy", 32'(bus.busy), 1);
    checkOutput("pre_reset_shift", 32'(bus.c4), 1);
    rst = 1'b0;
    #1;
    checkOutput("reset_outputs_async", 32'(outs_vec), 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("post_reset_busy", 32'(bus.busy), 0);
  endtask

  initial begin
    logic [1:0] opc;
    logic [7:0] x, y;
    int         yi;
    rst = 1'b0;
    bus.start = 1'b0;
    bus.op_in = 2'b00;
    inbus = 8'h00;
    flag_force = 1'b0;
    flag_val = 4'h0;
    #1;
    checkOutput("reset_state", 32'(outs_vec), 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("idle_after_reset", 32'(outs_vec), 0);

    applyStimulus(2'b00, 8'd25, 8'd17, 1);
    applyStimulus(2'b01, 8'd25, 8'd17, 1);
    applyStimulus(2'b10, 8'hFD, 8'd13, 1);
    applyStimulus(2'b11, 8'd100, 8'd7, 1);
    resetMidMul();
    applyStimulus(2'b10, 8'hFD, 8'd13, 1);
    applyStimulus(2'b11, 8'd100, 8'd7, 30);

    for (int n = 0; n < 24; n++) begin
      opc = 2'($urandom_range(0, 3));
      x = 8'($urandom);
      y = 8'($urandom);
      if (opc == 2'b10) begin
        yi = int'($urandom_range(0, 254)) - 127;
        y = 8'(yi);
      end else if (opc == 2'b11) begin
        y = 8'($urandom_range(1, 63));
      end
      applyStimulus(opc, x, y, 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
